// File: rtl/adc_psram_writer.sv
// adc_psram_writer
//   Capture stage between the ADC sampling block and the PSRAM controller,
//   clocked by clk_PSRAM. Four 12-bit samples are packed into each 64-bit
//   word and queued in a FIFO. The words then leave in fixed-length write
//   bursts at linearly increasing addresses that wrap inside the capture
//   region. The arm level input starts and stops the whole chain, including
//   the ADC enable.
//
//   Optional build macro: ADC_SEQ_TAG_EN. When it is defined, bits [15:12] of
//   each 16-bit lane carry a 4-bit per-sample sequence counter. When it is
//   undefined, those bits are zero.
//
// Ports
//   clk_PSRAM    single clock
//   rst          synchronous active-high reset
//   arm          level; capture runs while high, rising edge restarts
//   burst_limit  bursts per capture, 0 = continuous
//   psram_calib  PSRAM ready; no request is issued while low
//   adc_enable   registered enable to the ADC block (arm && state != DONE)
//   adc_ready    one-cycle sample strobe; adc_data valid with it
//   adc_data     12-bit sample
//   wr_req       burst request, held until wr_ack
//   wr_addr      burst start byte address
//   wr_ack       one-cycle request acceptance
//   wr_data      burst data word; wr_valid qualifies it
//   wr_valid     high for BURST_WORDS consecutive cycles per burst
//   done         burst_limit bursts completed
//   overflow     sticky, a packed word was dropped on a full FIFO
//   level        FIFO occupancy in words
module adc_psram_writer #(
  parameter int BURST_WORDS = 8,
  parameter int FIFO_DEPTH  = 32,
  parameter int ADDR_W      = 21,
  parameter int BASE_ADDR   = 0,
  parameter int SPAN_BYTES  = 2097152
) (
  input  logic                          clk_PSRAM,
  input  logic                          rst,
  input  logic                          arm,
  input  logic [15:0]                   burst_limit,
  input  logic                          psram_calib,
  output logic                          adc_enable,
  input  logic                          adc_ready,
  input  logic [11:0]                   adc_data,
  output logic                          wr_req,
  output logic [ADDR_W-1:0]             wr_addr,
  input  logic                          wr_ack,
  output logic [63:0]                   wr_data,
  output logic                          wr_valid,
  output logic                          done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int BEAT_W = $clog2(BURST_WORDS);
  localparam logic [ADDR_W:0]   STEP     = (ADDR_W+1)'(BURST_WORDS * 8);
  localparam logic [ADDR_W:0]   END_ADDR = (ADDR_W+1)'(BASE_ADDR + SPAN_BYTES);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

  state_t              state, state_nxt;
  logic                arm_q, arm_rise;
  logic                accept, pop, push_ok, last_beat, limit_hit;
  logic [1:0]          lane;
  logic [47:0]         partial;
  logic [15:0]         lane_word;
  logic [63:0]         word_p1;
  logic                vld_p1;
  logic [63:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [BEAT_W-1:0]   beat;
  logic [15:0]         burst_cnt;
  logic [ADDR_W:0]     addr_sum;

  assign arm_rise  = arm & ~arm_q;
  // A sample on the arming edge itself is dropped so the restart begins clean.
  assign accept    = adc_ready & arm & ~arm_rise & (state != DONE);
  assign pop       = (state == DATA);
  // A full FIFO still accepts a word when a pop frees a slot in the same cycle.
  assign push_ok   = vld_p1 & ((level != (AW+1)'(FIFO_DEPTH)) | pop);
  assign last_beat = pop & (beat == BEAT_W'(BURST_WORDS - 1));
  assign limit_hit = (burst_limit != 16'd0) && ((burst_cnt + 16'd1) == burst_limit);
  assign addr_sum  = {1'b0, wr_addr} + STEP;
  assign wr_data   = wr_valid ? mem[rd_ptr] : 64'd0;

`ifdef ADC_SEQ_TAG_EN
  logic [3:0] seq_cnt;

  always_ff @(posedge clk_PSRAM) begin
    if (rst || arm_rise) begin
      seq_cnt <= 4'd0;
    end else if (accept) begin
      seq_cnt <= seq_cnt + 4'd1;
    end
  end

  assign lane_word = {seq_cnt, adc_data};
`else
  assign lane_word = {4'b0000, adc_data};
`endif

  always_ff @(posedge clk_PSRAM) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wr_req    = 1'b0;
    wr_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (arm && psram_calib && (level >= (AW+1)'(BURST_WORDS))) state_nxt = REQ;
      end
      REQ: begin
        wr_req = 1'b1;
        if (wr_ack) state_nxt = DATA;
      end
      DATA: begin
        wr_valid = 1'b1;
        if (last_beat) state_nxt = limit_hit ? DONE : IDLE;
      end
      DONE: begin
        if (!arm) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0 -> p1: lane packing; the fourth sample closes the word.
  always_ff @(posedge clk_PSRAM) begin
    if (accept) begin
      case (lane)
        2'd0: partial[15:0]  <= lane_word;
        2'd1: partial[31:16] <= lane_word;
        2'd2: partial[47:32] <= lane_word;
        2'd3: word_p1        <= {lane_word, partial};
      endcase
    end
    // Stage p1 -> FIFO: write the completed word.
    if (push_ok) mem[wr_ptr] <= word_p1;
  end

  always_ff @(posedge clk_PSRAM) begin
    if (rst) begin
      arm_q      <= 1'b0;
      adc_enable <= 1'b0;
      lane       <= 2'd0;
      vld_p1     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      beat       <= '0;
      burst_cnt  <= 16'd0;
      wr_addr    <= BASE;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      arm_q      <= arm;
      adc_enable <= arm && (state != DONE);
      vld_p1     <= accept && (lane == 2'd3);
      // Disarming discards any partially filled group.
      if (arm_rise || !arm) begin
        lane <= 2'd0;
      end else if (accept) begin
        lane <= lane + 2'd1;
      end
      // Beat counter wraps to zero after the last word of each burst.
      beat <= pop ? beat + BEAT_W'(1) : '0;
      if (arm_rise) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        level     <= '0;
        overflow  <= 1'b0;
        done      <= 1'b0;
        burst_cnt <= 16'd0;
        wr_addr   <= BASE;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop)     rd_ptr <= rd_ptr + AW'(1);
        if (push_ok && !pop) begin
          level <= level + (AW+1)'(1);
        end else if (pop && !push_ok) begin
          level <= level - (AW+1)'(1);
        end
        if (vld_p1 && !push_ok) overflow <= 1'b1;
        if (last_beat) begin
          burst_cnt <= burst_cnt + 16'd1;
          wr_addr   <= (addr_sum == END_ADDR) ? BASE : addr_sum[ADDR_W-1:0];
          if (limit_hit) done <= 1'b1;
        end
      end
    end
  end

endmodule
